// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//
// Groups the request, operand and result signals of serial_adder into one bundle.
//
// Parameter:
//   WIDTH  operand and result width in bits (>= 2). Must match serial_adder.
//
// Signals (direction shown from the slave, i.e. the adder itself):
//   start  in   request to add; only honoured when the adder is free
//   a      in   operand A, captured on the accepted start
//   b      in   operand B, captured on the accepted start
//   cin    in   carry-in, captured on the accepted start
//   busy   out  high while operand bits are being processed
//   done   out  one-cycle pulse; sum/cout (and ovf) are valid in that cycle
//   sum    out  result register
//   cout   out  final carry-out
//   ovf    out  signed overflow; exists only when SERIAL_ADDER_OVF_EN is defined
//
// Modports:
//   master  the requester; drives start/a/b/cin and observes the results
//   slave   the adder; drives busy/done/sum/cout/ovf
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface : serial_adder_if

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder built around a single-bit full_adder cell. Each
// clock the cell is fed one operand bit pair (LSB first) together with the
// stored carry. Its sum bit is shifted into the top of the result register and
// its carry is stored in the carry flop for the next bit. This trades WIDTH+1
// cycles of latency for a single adder cell.
//
//   {cout, sum} = a + b + cin   (unsigned, no saturation)
//
// Parameter:
//   WIDTH  operand and result width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock; the only clock
//   rst_n  synchronous active-low reset; aborts any operation in flight
//   bus    serial_adder_if.slave: start/a/b/cin in; busy/done/sum/cout(/ovf) out
//
// Optional feature:
//   SERIAL_ADDER_OVF_EN  when defined, adds the signed-overflow output ovf
//                        (carry into MSB XOR carry out of MSB), valid with done
//                        and held like cout.
//
// Timing (start sampled at edge N):
//   busy  high for the WIDTH cycles after edges N .. N+WIDTH-1
//   done  high for the single cycle after edge N+WIDTH
//   The closing edge of the done cycle (N+WIDTH+1) is the first edge that may
//   accept a new start, so the minimum issue interval is WIDTH+1 cycles.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------

// Single-bit full adder cell: i0 + i1 + i2 -> {carry, sum}.
module full_adder (
  input  logic i0_i,
  input  logic i1_i,
  input  logic i2_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = i0_i ^ i1_i ^ i2_i;
  assign carry_o = (i0_i & i1_i) | (i0_i & i2_i) | (i1_i & i2_i);

endmodule : full_adder

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  // Counter just wide enough to index bits 0 .. WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_carry;
  logic last_bit;
  logic accept;

  // The one and only adder cell: current LSBs of both operands plus stored carry.
  full_adder u_fa (
    .i0_i    (a_sh_q[0]),
    .i1_i    (b_sh_q[0]),
    .i2_i    (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // A request is taken in IDLE and on the closing edge of the DONE cycle; the
  // latter is what lets a continuously held start re-launch every WIDTH+1
  // cycles. Starts arriving while bits are being shifted are dropped.
  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      SHIFT: begin
        // Consume one bit pair: operands move toward bit 0, the new sum bit
        // enters at the top so bit 0 ends up in sum[0] after WIDTH steps.
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB, fa_carry the carry out of it.
          ovf_d   = carry_q ^ fa_carry;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Launch overrides whatever the idle/done branches chose. cout (and ovf)
    // keep the previous result until the new one is complete.
    if (accept) begin
      state_d = SHIFT;
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      sum_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // not in the sensitivity list; all state uses non-blocking assignment so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven directly by flops
  // ---------------------------------------------------------------------------
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Scoreboard bench for serial_adder (WIDTH = 8). Every accepted start pushes
// the expected {sum, cout, ovf} and the launch cycle; a monitor on the falling
// edge pops and compares on each done pulse, also checking latency and the
// number of busy cycles. ovf is compared only when SERIAL_ADDER_OVF_EN is
// defined. Inputs change 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               launch;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_vec     = 0;
  int n_miss    = 0;
  int cyc       = 0;
  int busy_cnt  = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full-width sum for sum/cout; a separate (WIDTH-1)-bit add gives
  // the carry into the MSB for the signed-overflow flag.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input int launch);
    exp_t             e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + WIDTH'(cin);
    e.sum    = full[WIDTH-1:0];
    e.cout   = full[WIDTH];
    e.ovf    = low[WIDTH-1] ^ full[WIDTH];
    e.launch = launch;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_seen++;
        check("busy_done_excl", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sum",      32'(bus.sum),  32'(mon_e.sum));
          check("cout",     32'(bus.cout), 32'(mon_e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf",      32'(bus.ovf),  32'(mon_e.ovf));
`endif
          check("latency",  32'(cyc - mon_e.launch), 32'(WIDTH));
          check("busy_len", 32'(busy_cnt), 32'(WIDTH));
        end
        busy_cnt = 0;
      end
    end
  end

  // One-cycle start pulse; optionally record the expected result.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input bit push);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back(model(a, b, cin, cyc));
    #1;
    bus.start = 1'b0;
  endtask

  // Bounded wait for all outstanding results, then one idle cycle.
  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_sum"},  32'(bus.sum),  32'd0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"},  32'(bus.ovf),  32'd0);
`endif
  endtask

  int saved;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Zero operands, then carry-ripple and signed-overflow boundaries.
    launch(8'h00, 8'h00, 1'b0, 1'b1);
    wait_drain(20);
    launch(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_drain(20);
    launch(8'h7F, 8'h01, 1'b0, 1'b1);
    wait_drain(20);

    // Start during busy (cycle 4) must be ignored; original result stands.
    launch(8'hA5, 8'h5A, 1'b1, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check("busy_mid", 32'(bus.busy), 32'd1);
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_drain(20);
    check("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Reset mid-operation: outputs clear, no done for the aborted operation.
    launch(8'h3C, 8'h0F, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("abort");
    #1;
    rst_n = 1'b1;
    saved = done_seen;
    repeat (12) begin
      @(posedge clk);
      #2;
    end
    check("abort_no_done", 32'(done_seen), 32'(saved));
    launch(8'h3C, 8'h0F, 1'b0, 1'b1);
    wait_drain(20);

    // Start held high for 30 cycles: re-launch every WIDTH+1 cycles.
    saved     = done_seen;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i % (WIDTH + 1) == 0) sb.push_back(model(8'h10, 8'h20, 1'b0, cyc));
      #1;
    end
    bus.start = 1'b0;
    wait_drain(40);
    check("held_done_count", 32'(done_seen - saved), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #20000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_serial_adder
